// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among several pipelined
// cores. One load or store is granted per cycle; losers are held with a stall
// level, a combined store+load is split store-first, and load data is routed
// back to its issuer through a latency-matched tag pipe. A drain mode lets the
// port be quiesced before halt.
module mem_port_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int MEM_LATENCY = 2,
  parameter int STALL_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [16*NUM_CORES-1:0]  core_raddr,
  input  logic [NUM_CORES-1:0]     core_wen,
  input  logic [15*NUM_CORES-1:0]  core_waddr,
  input  logic [16*NUM_CORES-1:0]  core_wdata,
  output logic [17*NUM_CORES-1:0]  core_rdata,
  output logic [3*NUM_CORES-1:0]   core_stall,
  output logic [15:0]              mem_raddr,
  input  logic [16:0]              mem_rdata,
  output logic                     mem_wen,
  output logic [14:0]              mem_waddr,
  output logic [15:0]              mem_wdata,
  input  logic                     drain_req,
  output logic                     drained
);

  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [2:0] STALL = 3'(STALL_LEVEL);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t state, state_n;

  logic [ID_W-1:0] rr_ptr, rr_n;
  logic [ID_W-1:0] wd_id, wd_id_n;
  logic            write_done, wd_n;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            push;
  logic [ID_W-1:0] push_id;

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] rd_req;
  logic [15:0]          raddr_a [NUM_CORES];
  logic [14:0]          waddr_a [NUM_CORES];
  logic [15:0]          wdata_a [NUM_CORES];
  logic [2:0]           stall_a [NUM_CORES];

  // Tag pipe: index 0 is written on a read grant, the last entry is the head
  // that lines up with mem_rdata MEM_LATENCY cycles after the grant.
  logic [MEM_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]        tag_id [MEM_LATENCY];

  logic            head_v;
  logic [ID_W-1:0] head_id;
  logic            pipe_empty;

  assign head_v     = tag_v[MEM_LATENCY-1];
  assign head_id    = tag_id[MEM_LATENCY-1];
  assign pipe_empty = (tag_v == '0);

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    next_ptr = (p == ID_W'(NUM_CORES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Unpack the flat per-core buses and derive each core's request.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      raddr_a[i] = core_raddr[16*i +: 16];
      waddr_a[i] = core_waddr[15*i +: 15];
      wdata_a[i] = core_wdata[16*i +: 16];
      rd_req[i]  = core_raddr[16*i + 15];
      req[i]     = core_wen[i] | core_raddr[16*i + 15];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Grant decision, memory-port drive, stall levels and FSM next state.
  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    wd_n      = write_done;
    wd_id_n   = wd_id;
    push      = 1'b0;
    push_id   = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    drained   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      stall_a[i] = req[i] ? STALL : 3'd0;
    end

    if (!rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        stall_a[i] = STALL;
      end
    end else begin
      drained = (state == DRAINED);

      if (write_done) begin
        // Second half of a store-first split: the read jumps the rr order
        // and is allowed even while draining.
        mem_raddr        = raddr_a[wd_id];
        push             = rd_req[wd_id];
        push_id          = wd_id;
        stall_a[wd_id]   = 3'd0;
        rr_n             = next_ptr(wd_id);
        wd_n             = 1'b0;
      end else if (state == RUN && !drain_req && found) begin
        if (core_wen[winner] && rd_req[winner]) begin
          // Store now, keep the core stalled so it holds its read for next cycle.
          mem_wen         = 1'b1;
          mem_waddr       = waddr_a[winner];
          mem_wdata       = wdata_a[winner];
          stall_a[winner] = STALL;
          wd_n            = 1'b1;
          wd_id_n         = winner;
        end else begin
          if (core_wen[winner]) begin
            mem_wen   = 1'b1;
            mem_waddr = waddr_a[winner];
            mem_wdata = wdata_a[winner];
          end
          if (rd_req[winner]) begin
            mem_raddr = raddr_a[winner];
            push      = 1'b1;
            push_id   = winner;
          end
          stall_a[winner] = 3'd0;
          rr_n            = next_ptr(winner);
        end
      end

      case (state)
        RUN:     if (drain_req) state_n = DRAIN;
        DRAIN:   if (pipe_empty && !write_done) state_n = DRAINED;
        DRAINED: if (!drain_req) state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  // Pack stall levels onto the flat output bus.
  always_comb begin
    core_stall = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_stall[3*i +: 3] = stall_a[i];
    end
  end

  // Route returning memory data to the core named by the head tag only.
  always_comb begin
    core_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rst_n && head_v && head_id == ID_W'(i)) begin
        core_rdata[17*i +: 17] = mem_rdata;
      end
    end
  end

  // State, round-robin pointer, split flag and tag pipe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      rr_ptr     <= '0;
      write_done <= 1'b0;
      wd_id      <= '0;
      tag_v      <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      write_done <= wd_n;
      wd_id      <= wd_id_n;
      tag_v[0]   <= push;
      tag_id[0]  <= push_id;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (4 cores, latency 2, stall level 6).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 1 unit later, well before the next edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [63:0] core_raddr;
  logic [3:0]  core_wen;
  logic [59:0] core_waddr;
  logic [63:0] core_wdata;
  logic [67:0] core_rdata;
  logic [11:0] core_stall;
  logic [15:0] mem_raddr;
  logic [16:0] mem_rdata;
  logic        mem_wen;
  logic [14:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        drain_req;
  logic        drained;

  int tests  = 0;
  int failed = 0;

  mem_port_arbiter #(.NUM_CORES(4), .MEM_LATENCY(2), .STALL_LEVEL(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_raddr (core_raddr),
    .core_wen   (core_wen),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .drain_req  (drain_req),
    .drained    (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set one core's read/store request.
  task automatic applyStimulus(input int core, input logic rd, input logic [14:0] raddr,
                               input logic wr, input logic [14:0] waddr,
                               input logic [15:0] wdata);
    core_raddr[16*core +: 16] = {rd, raddr};
    core_wen[core]            = wr;
    core_waddr[15*core +: 15] = waddr;
    core_wdata[16*core +: 16] = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    core_raddr = '0;
    core_wen   = '0;
    core_waddr = '0;
    core_wdata = '0;
    mem_rdata  = '0;
    drain_req  = 1'b0;

    // Reset: outputs forced even with a requester and stray memory data.
    applyStimulus(0, 1'b1, 15'h0010, 1'b0, 15'h0, 16'h0);
    mem_rdata = 17'h1FFFF;
    tick();
    tick();
    checkOutput("rst_stall", core_stall, 12'hDB6);
    checkOutput("rst_raddr", mem_raddr, 16'h0);
    checkOutput("rst_wen", mem_wen, 1'b0);
    checkOutput("rst_rdata", core_rdata, 68'h0);
    checkOutput("rst_drained", drained, 1'b0);

    // Idle after reset.
    applyStimulus(0, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    mem_rdata = '0;
    rst_n = 1'b1;
    #1;
    checkOutput("idle_raddr", mem_raddr, 16'h0);
    checkOutput("idle_stall", core_stall, 12'h000);
    tick();

    // Single read from core 0, data back two cycles after grant.
    applyStimulus(0, 1'b1, 15'h0010, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("t1_raddr", mem_raddr, 16'h8010);
    checkOutput("t1_stall", core_stall, 12'h000);
    tick();
    applyStimulus(0, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("t1_early", core_rdata, 68'h0);
    tick();
    mem_rdata = 17'h11234;
    #1;
    checkOutput("t1_rdata0", core_rdata[16:0], 17'h11234);
    checkOutput("t1_others", core_rdata[67:17], 51'h0);
    tick();
    mem_rdata = '0;

    // Store-first split on core 3 (rr_ptr is 1 here).
    applyStimulus(3, 1'b1, 15'h0041, 1'b1, 15'h0040, 16'hBEEF);
    #1;
    checkOutput("sp_wen1", mem_wen, 1'b1);
    checkOutput("sp_waddr", mem_waddr, 15'h0040);
    checkOutput("sp_wdata", mem_wdata, 16'hBEEF);
    checkOutput("sp_raddr1", mem_raddr, 16'h0);
    checkOutput("sp_stall1", core_stall[11:9], 3'd6);
    tick();
    #1;
    checkOutput("sp_wen2", mem_wen, 1'b0);
    checkOutput("sp_raddr2", mem_raddr, 16'h8041);
    checkOutput("sp_stall2", core_stall[11:9], 3'd0);
    tick();
    applyStimulus(3, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    tick();
    mem_rdata = 17'h15A5A;
    #1;
    checkOutput("sp_rdata3", core_rdata[67:51], 17'h15A5A);
    tick();
    mem_rdata = '0;

    // Three simultaneous reads with rr_ptr back at 0.
    applyStimulus(0, 1'b1, 15'h0100, 1'b0, 15'h0, 16'h0);
    applyStimulus(1, 1'b1, 15'h0101, 1'b0, 15'h0, 16'h0);
    applyStimulus(2, 1'b1, 15'h0102, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("rr_raddr0", mem_raddr, 16'h8100);
    checkOutput("rr_stall0", core_stall, 12'h1B0);
    tick();
    applyStimulus(0, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("rr_raddr1", mem_raddr, 16'h8101);
    checkOutput("rr_stall1", core_stall, 12'h180);
    tick();
    applyStimulus(1, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    mem_rdata = 17'h1A000;
    #1;
    checkOutput("rr_raddr2", mem_raddr, 16'h8102);
    checkOutput("rr_stall2", core_stall, 12'h000);
    checkOutput("rr_data0", core_rdata[16:0], 17'h1A000);
    checkOutput("rr_data0_oth", core_rdata[67:17], 51'h0);
    tick();
    applyStimulus(2, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    mem_rdata = 17'h1A001;
    #1;
    checkOutput("rr_data1", core_rdata[33:17], 17'h1A001);
    checkOutput("rr_data1_c0", core_rdata[16:0], 17'h0);
    tick();
    mem_rdata = 17'h1A002;
    #1;
    checkOutput("rr_data2", core_rdata[50:34], 17'h1A002);
    tick();
    mem_rdata = 17'h1DEAD;
    #1;
    checkOutput("stray_rdata", core_rdata, 68'h0);
    tick();
    mem_rdata = '0;

    // Wrap: rr_ptr is 3, cores 0 and 3 request.
    applyStimulus(0, 1'b1, 15'h0200, 1'b0, 15'h0, 16'h0);
    applyStimulus(3, 1'b1, 15'h0203, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("wrap_raddr0", mem_raddr, 16'h8203);
    checkOutput("wrap_stall0", core_stall, 12'h006);
    tick();
    applyStimulus(3, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("wrap_raddr1", mem_raddr, 16'h8200);
    checkOutput("wrap_stall1", core_stall, 12'h000);
    tick();
    applyStimulus(0, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    tick();
    tick();

    // Drain with two reads in flight (rr_ptr is 1).
    applyStimulus(1, 1'b1, 15'h0300, 1'b0, 15'h0, 16'h0);
    applyStimulus(2, 1'b1, 15'h0301, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("dr_raddr0", mem_raddr, 16'h8300);
    tick();
    applyStimulus(1, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("dr_raddr1", mem_raddr, 16'h8301);
    tick();
    applyStimulus(2, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    applyStimulus(0, 1'b1, 15'h0302, 1'b0, 15'h0, 16'h0);
    drain_req = 1'b1;
    mem_rdata = 17'h11111;
    #1;
    checkOutput("dr_nogrant0", mem_raddr, 16'h0);
    checkOutput("dr_stall0", core_stall, 12'h006);
    checkOutput("dr_data1", core_rdata[33:17], 17'h11111);
    checkOutput("dr_drained0", drained, 1'b0);
    tick();
    mem_rdata = 17'h12222;
    #1;
    checkOutput("dr_data2", core_rdata[50:34], 17'h12222);
    checkOutput("dr_nogrant1", mem_raddr, 16'h0);
    checkOutput("dr_drained1", drained, 1'b0);
    tick();
    mem_rdata = '0;
    #1;
    checkOutput("dr_drained2", drained, 1'b0);
    checkOutput("dr_stall2", core_stall, 12'h006);
    tick();
    #1;
    checkOutput("dr_drained3", drained, 1'b1);
    checkOutput("dr_nogrant3", mem_raddr, 16'h0);
    drain_req = 1'b0;
    tick();
    #1;
    checkOutput("dr_resume", mem_raddr, 16'h8302);
    checkOutput("dr_resume_st", core_stall, 12'h000);
    checkOutput("dr_run", drained, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    tick();
    tick();

    // Reset with a read in flight; stale data must not be delivered.
    applyStimulus(1, 1'b1, 15'h0400, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("rs_raddr", mem_raddr, 16'h8400);
    tick();
    applyStimulus(1, 1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_stall", core_stall, 12'hDB6);
    checkOutput("rs_drained", drained, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_rdata = 17'h1BAD0;
    #1;
    checkOutput("rs_stale", core_rdata, 68'h0);
    tick();
    mem_rdata = '0;
    applyStimulus(0, 1'b1, 15'h0500, 1'b0, 15'h0, 16'h0);
    applyStimulus(1, 1'b1, 15'h0501, 1'b0, 15'h0, 16'h0);
    #1;
    checkOutput("rs_rrptr", mem_raddr, 16'h8500);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
